// File: rtl/v15_pulse_source_pkg.sv
// Shared widths, tuning defaults and the decay-step helper for the v15 synthetic pulse source.
// The decay/baseline defaults are the same values the v15 shaping filter is tuned against.
package v15_pulse_source_pkg;

  localparam int unsigned SIZE_ADC_DATA = 12;

  localparam int unsigned V15_PULSE_DECAY_SHIFT = 4;
  localparam logic [SIZE_ADC_DATA-1:0] V15_PULSE_BASELINE = '0;

  typedef logic [SIZE_ADC_DATA-1:0] adc_t;

  typedef enum logic {
    StIdle,
    StDecay
  } pulse_state_e;

  // Falls back to a unit step once the shifted term underflows, so the tail always reaches 0.
  function automatic adc_t decay_step(adc_t a, int unsigned shift);
    adc_t drop;
    drop = a >> shift;
    if (drop != '0) begin
      return a - drop;
    end else if (a != '0) begin
      return a - adc_t'(1);
    end else begin
      return '0;
    end
  endfunction

endpackage

// File: rtl/v15_pulse_source_if.sv
// Control and sample-stream bundle of the synthetic pulse source.
// master = stimulus side, slave = the pulse source itself.
interface v15_pulse_source_if #(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned COUNT_W  = 16
) ();
  import v15_pulse_source_pkg::*;

  logic                start;
  adc_t                amplitude;
  logic [PERIOD_W-1:0] period;
  adc_t                output_data;
  logic                pulse_strobe;
  logic                busy;
  logic [COUNT_W-1:0]  pulse_count;

  modport master (
    output start,
    output amplitude,
    output period,
    input  output_data,
    input  pulse_strobe,
    input  busy,
    input  pulse_count
  );

  modport slave (
    input  start,
    input  amplitude,
    input  period,
    output output_data,
    output pulse_strobe,
    output busy,
    output pulse_count
  );

endinterface

// File: rtl/v15_pulse_source_sat_add.sv
// Combinational unsigned adder that clamps to all-ones on carry-out.
module v15_pulse_source_sat_add #(
  parameter int unsigned Width = 12
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] sum_o
);

  logic [Width:0] full_sum;

  assign full_sum = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o    = full_sum[Width] ? '1 : full_sum[Width-1:0];

endmodule

// File: rtl/v15_pulse_source.sv
// Step-exponential pulse generator with pile-up, one-shot or periodic triggering.
// acc holds the tail; the output stage adds BASELINE one register later.
module v15_pulse_source
  import v15_pulse_source_pkg::*;
#(
  parameter int unsigned               DECAY_SHIFT = V15_PULSE_DECAY_SHIFT,
  parameter logic [SIZE_ADC_DATA-1:0]  BASELINE    = V15_PULSE_BASELINE,
  parameter int unsigned               PERIOD_W    = 16,
  parameter int unsigned               COUNT_W     = 16
) (
  input logic               clk,
  input logic               reset,
  v15_pulse_source_if.slave bus
);

  pulse_state_e        state_q;
  adc_t                acc_q;
  adc_t                acc_d;
  adc_t                decayed;
  adc_t                addend;
  adc_t                out_sum;
  logic                trigger;
  logic                trig_q;
  logic [PERIOD_W-1:0] period_cnt_q;
  logic [COUNT_W-1:0]  pulse_count_q;
  adc_t                output_q;
  logic                strobe_q;
  logic                busy_q;

  assign trigger = bus.start | ((bus.period != '0) && (period_cnt_q == PERIOD_W'(1)));
  assign decayed = decay_step(acc_q, DECAY_SHIFT);
  assign addend  = trigger ? bus.amplitude : '0;

  v15_pulse_source_sat_add #(
    .Width(SIZE_ADC_DATA)
  ) u_pileup_add (
    .a_i  (decayed),
    .b_i  (addend),
    .sum_o(acc_d)
  );

  v15_pulse_source_sat_add #(
    .Width(SIZE_ADC_DATA)
  ) u_baseline_add (
    .a_i  (BASELINE),
    .b_i  (acc_q),
    .sum_o(out_sum)
  );

  // Output, busy and strobe lag acc by one register so all three line up on output_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      acc_q         <= '0;
      trig_q        <= 1'b0;
      period_cnt_q  <= '0;
      pulse_count_q <= '0;
      output_q      <= '0;
      strobe_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      acc_q <= acc_d;
      case (state_q)
        StIdle:  if (acc_d != '0) state_q <= StDecay;
        StDecay: if (acc_d == '0) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (trigger || (period_cnt_q == '0)) begin
        period_cnt_q <= bus.period;
      end else begin
        period_cnt_q <= period_cnt_q - PERIOD_W'(1);
      end

      if (trigger) begin
        pulse_count_q <= pulse_count_q + COUNT_W'(1);
      end

      trig_q   <= trigger;
      strobe_q <= trig_q;
      output_q <= out_sum;
      busy_q   <= (state_q == StDecay);
    end
  end

  assign bus.output_data  = output_q;
  assign bus.pulse_strobe = strobe_q;
  assign bus.busy         = busy_q;
  assign bus.pulse_count  = pulse_count_q;

endmodule

// File: tb/tb_v15_pulse_source.sv
// Bench for v15_pulse_source: two instances (BASELINE 100 / 16-bit count, BASELINE 0 / 4-bit
// count) share stimulus and are compared every cycle against an integer reference model.
module tb_v15_pulse_source;
  import v15_pulse_source_pkg::*;

  localparam int MAXV   = (1 << SIZE_ADC_DATA) - 1;
  localparam int BASE_A = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  int   amp = 0;
  int   period = 0;

  always #5 clk = ~clk;

  v15_pulse_source_if #(.PERIOD_W(16), .COUNT_W(16)) bus_a ();
  v15_pulse_source_if #(.PERIOD_W(16), .COUNT_W(4))  bus_b ();

  assign bus_a.start     = start;
  assign bus_a.amplitude = adc_t'(amp);
  assign bus_a.period    = 16'(period);
  assign bus_b.start     = start;
  assign bus_b.amplitude = adc_t'(amp);
  assign bus_b.period    = 16'(period);

  v15_pulse_source #(
    .DECAY_SHIFT(4), .BASELINE(12'd100), .PERIOD_W(16), .COUNT_W(16)
  ) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  v15_pulse_source #(
    .DECAY_SHIFT(4), .BASELINE(12'd0), .PERIOD_W(16), .COUNT_W(4)
  ) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(string name, int actual, int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Reference model: tail value, pending strobe, cycles-to-auto-trigger, accepted triggers.
  int m_acc = 0, m_trig = 0, m_cnt = 0, m_count = 0;
  int e_out_a = 0, e_out_b = 0, e_strobe = 0, e_busy = 0;

  function automatic int model_decay(int a);
    if ((a >> 4) != 0) return a - (a >> 4);
    if (a > 0) return a - 1;
    return 0;
  endfunction

  task automatic cycle();
    int trig;
    @(posedge clk);
    if (reset) begin
      m_acc = 0; m_trig = 0; m_cnt = 0; m_count = 0;
      e_out_a = 0; e_out_b = 0; e_strobe = 0; e_busy = 0;
    end else begin
      e_out_a  = (BASE_A + m_acc > MAXV) ? MAXV : BASE_A + m_acc;
      e_out_b  = m_acc;
      e_busy   = (m_acc > 0) ? 1 : 0;
      e_strobe = m_trig;
      trig     = (start || (period != 0 && m_cnt == 1)) ? 1 : 0;
      m_acc    = model_decay(m_acc) + (trig ? amp : 0);
      if (m_acc > MAXV) m_acc = MAXV;
      m_cnt    = (trig || m_cnt == 0) ? period : m_cnt - 1;
      m_count  = m_count + trig;
      m_trig   = trig;
    end
    #1;
    check("model_out_a", int'(bus_a.output_data), e_out_a);
    check("model_out_b", int'(bus_b.output_data), e_out_b);
    check("model_strobe_a", int'(bus_a.pulse_strobe), e_strobe);
    check("model_strobe_b", int'(bus_b.pulse_strobe), e_strobe);
    check("model_busy_a", int'(bus_a.busy), e_busy);
    check("model_busy_b", int'(bus_b.busy), e_busy);
    check("model_count_a", int'(bus_a.pulse_count), m_count % 65536);
    check("model_count_b", int'(bus_b.pulse_count), m_count % 16);
  endtask

  task automatic wait_idle(string name, int budget);
    int n;
    n = 0;
    while (bus_b.busy && n < budget) begin
      cycle();
      n++;
    end
    check({name, "_idle_timeout"}, int'(bus_b.busy), 0);
  endtask

  typedef struct {
    logic st;
    int   a;
    int   exp_a;
    int   exp_b;
    int   exp_strobe;
    int   exp_busy;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   small_exp[6];
    int   cnt0, prev_busy, found, bad, nstrobe, exp_s;

    vecs[0] = '{1'b1, 1024, 100,  0,    0, 0};
    vecs[1] = '{1'b0, 0,    1124, 1024, 1, 1};
    vecs[2] = '{1'b0, 0,    1060, 960,  0, 1};
    vecs[3] = '{1'b0, 0,    1000, 900,  0, 1};
    vecs[4] = '{1'b0, 0,    944,  844,  0, 1};
    small_exp = '{5, 4, 3, 2, 1, 0};

    // Reset state and release
    reset = 1'b1;
    repeat (3) cycle();
    check("reset_out", int'(bus_a.output_data), 0);
    check("reset_busy", int'(bus_a.busy), 0);
    check("reset_count", int'(bus_a.pulse_count), 0);
    reset = 1'b0;
    cycle();
    check("release_baseline", int'(bus_a.output_data), 100);

    // Single pulse, table-driven
    for (int i = 0; i < 5; i++) begin
      start = vecs[i].st;
      amp   = vecs[i].a;
      cycle();
      check($sformatf("vec%0d_out_a", i), int'(bus_a.output_data), vecs[i].exp_a);
      check($sformatf("vec%0d_out_b", i), int'(bus_b.output_data), vecs[i].exp_b);
      check($sformatf("vec%0d_strobe", i), int'(bus_a.pulse_strobe), vecs[i].exp_strobe);
      check($sformatf("vec%0d_busy", i), int'(bus_a.busy), vecs[i].exp_busy);
    end

    // Tail lands exactly on baseline with busy dropping in the same cycle
    found = 0;
    prev_busy = 1;
    for (int i = 0; i < 400 && !found; i++) begin
      prev_busy = int'(bus_a.busy);
      cycle();
      if (bus_a.output_data == 12'd100) found = 1;
    end
    check("tail_reaches_baseline", found, 1);
    check("tail_busy_drop", int'(bus_a.busy), 0);
    check("tail_busy_before", prev_busy, 1);

    // Pile-up with saturation
    cnt0 = int'(bus_b.pulse_count);
    start = 1'b1; amp = 3000;
    cycle();
    start = 1'b0;
    cycle();
    check("pile_first", int'(bus_b.output_data), 3000);
    check("pile_first_strobe", int'(bus_b.pulse_strobe), 1);
    start = 1'b1;
    cycle();
    check("pile_decay", int'(bus_b.output_data), 2813);
    start = 1'b0;
    cycle();
    check("pile_sat_b", int'(bus_b.output_data), 4095);
    check("pile_sat_a", int'(bus_a.output_data), 4095);
    check("pile_strobe2", int'(bus_b.pulse_strobe), 1);
    check("pile_count", int'(bus_b.pulse_count), (cnt0 + 2) % 16);

    // Reset mid-tail discards it
    repeat (3) cycle();
    reset = 1'b1;
    repeat (3) cycle();
    check("midreset_out", int'(bus_a.output_data), 0);
    check("midreset_busy", int'(bus_a.busy), 0);
    check("midreset_count", int'(bus_a.pulse_count), 0);
    check("midreset_strobe", int'(bus_a.pulse_strobe), 0);
    reset = 1'b0;
    cycle();
    check("midreset_release_a", int'(bus_a.output_data), 100);
    check("midreset_release_b", int'(bus_b.output_data), 0);

    // Small tail steps linearly to 0
    start = 1'b1; amp = 5;
    cycle();
    start = 1'b0; amp = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check($sformatf("small_out%0d", i), int'(bus_b.output_data), small_exp[i]);
      check($sformatf("small_busy%0d", i), int'(bus_b.busy), (i < 5) ? 1 : 0);
    end
    cycle();
    check("small_idle", int'(bus_b.busy), 0);

    // Counter wrap with zero-amplitude triggers
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    start = 1'b1; amp = 0;
    repeat (17) cycle();
    start = 1'b0;
    cycle();
    check("wrap_count_b", int'(bus_b.pulse_count), 1);
    check("wrap_count_a", int'(bus_a.pulse_count), 17);
    check("wrap_amp0_idle", int'(bus_a.busy), 0);

    // Periodic mode; index 0 is the first edge after reset release
    reset = 1'b1; period = 50; amp = 200; start = 1'b0;
    cycle();
    reset = 1'b0;
    bad = 0; nstrobe = 0;
    for (int cyc = 0; cyc <= 502; cyc++) begin
      start = (cyc == 500);
      cycle();
      if (cyc == 0) check("periodic_baseline", int'(bus_a.output_data), 100);
      exp_s = (cyc >= 51 && cyc % 50 == 1) ? 1 : 0;
      if (int'(bus_a.pulse_strobe) != exp_s) bad++;
      if (cyc < 500 && bus_a.pulse_strobe) nstrobe++;
      if (cyc == 499) check("periodic_count9", int'(bus_a.pulse_count), 9);
      if (cyc == 500) check("coincident_count", int'(bus_a.pulse_count), 10);
    end
    start = 1'b0;
    check("periodic_strobe_mismatches", bad, 0);
    check("periodic_strobes", nstrobe, 9);

    // Randomized traffic against the model
    period = 0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 11) == 0);
      amp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, MAXV);
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 3))
          0: period = 0;
          1: period = 1;
          default: period = $urandom_range(2, 40);
        endcase
      end
      cycle();
    end
    reset = 1'b0; start = 1'b0; period = 0;
    wait_idle("final", 1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
